// File: rtl/mag_cmp_pkg.sv
// rtl/mag_cmp_pkg.sv - shared FSM state and result encodings for the sequential magnitude comparator
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Result vector ordering is {less, equal, greater}
    typedef logic [2:0] result_t;

    localparam result_t RES_NONE    = 3'b000;
    localparam result_t RES_LESS    = 3'b100;
    localparam result_t RES_EQUAL   = 3'b010;
    localparam result_t RES_GREATER = 3'b001;

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational STEP-bit chunk compare with optional sign-bit flip on the MSB
module chunk_cmp #(
    parameter int STEP = 4
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    input  logic            msb_signed,
    output logic            lt,
    output logic            eq,
    output logic            gt
);

    logic [STEP-1:0] xs;
    logic [STEP-1:0] ys;

    // Inverting the sign bit maps two's-complement order onto unsigned order
    always_comb begin
        xs = x;
        ys = y;
        if (msb_signed) begin
            xs[STEP-1] = ~x[STEP-1];
            ys[STEP-1] = ~y[STEP-1];
        end
    end

    assign lt = (xs <  ys);
    assign eq = (xs == ys);
    assign gt = (xs >  ys);

endmodule

// File: rtl/mag_compare_seq.sv
// rtl/mag_compare_seq.sv - MSB-first chunked magnitude comparator; MAG_CMP_SIGNED_EN adds signed_mode
module mag_compare_seq
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MAG_CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             ready,
    output logic             done,
    output logic             less,
    output logic             equal,
    output logic             greater
);

    localparam int N     = WIDTH / STEP;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    generate
        if ((WIDTH % STEP) != 0) begin : g_bad_cfg
            $error("mag_compare_seq: WIDTH must be a multiple of STEP");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    result_t          res_q, res_d;
    logic             sgn_cur;
    logic             accept;
    logic [STEP-1:0]  chunk_a, chunk_b;
    logic             c_lt, c_eq, c_gt;

    assign accept  = start && (state_q != ST_COMPARE);
    assign chunk_a = a_q[idx_q*STEP +: STEP];
    assign chunk_b = b_q[idx_q*STEP +: STEP];

`ifdef MAG_CMP_SIGNED_EN
    logic sgn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q <= 1'b0;
        end else if (accept) begin
            sgn_q <= signed_mode;
        end
    end

    assign sgn_cur = sgn_q;
`else
    assign sgn_cur = 1'b0;
`endif

    chunk_cmp #(.STEP(STEP)) u_chunk_cmp (
        .x          (chunk_a),
        .y          (chunk_b),
        .msb_signed (sgn_cur && (idx_q == IDX_TOP)),
        .lt         (c_lt),
        .eq         (c_eq),
        .gt         (c_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_COMPARE;
                    idx_d   = IDX_TOP;
                    a_d     = a;
                    b_d     = b;
                    res_d   = RES_NONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                // First differing chunk decides; lower chunks cannot change the outcome
                if (!c_eq) begin
                    state_d = ST_DONE;
                    res_d   = c_lt ? RES_LESS : (c_gt ? RES_GREATER : RES_NONE);
                end else if (idx_q == '0) begin
                    state_d = ST_DONE;
                    res_d   = RES_EQUAL;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q != ST_COMPARE);
        done    = (state_q == ST_DONE);
        less    = res_q[2];
        equal   = res_q[1];
        greater = res_q[0];
    end

endmodule

// File: tb/tb_mag_compare_seq.sv
// tb/tb_mag_compare_seq.sv - scoreboard bench for mag_compare_seq
module tb_mag_compare_seq;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sm = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, done, less, equal, greater;

    always #5 clk = ~clk;

    mag_compare_seq #(.WIDTH(W), .STEP(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef MAG_CMP_SIGNED_EN
        .signed_mode (sm),
`endif
        .ready       (ready),
        .done        (done),
        .less        (less),
        .equal       (equal),
        .greater     (greater)
    );

    typedef struct {
        logic [2:0] res;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         last_done_cyc = -100;
    logic [2:0] last_res = 3'b000;
    logic       prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: whole-operand integer compare, {less,equal,greater}
    function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        if (s) begin
            if ($signed(x) < $signed(y)) return 3'b100;
            if ($signed(x) > $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x < y) return 3'b100;
        if (x > y) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int k = 1; k <= N; k++) begin
            if (x[W-k*S +: S] != y[W-k*S +: S]) return k;
        end
        return N;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) chk("done_one_cycle", done, 1'b0);
            if (done) begin
                last_done_cyc = cyc;
                chk("ready_in_done", ready, 1'b1);
                chk("done_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", {less, equal, greater}, e.res);
                    chk("latency", cyc - e.acc, e.lat);
                    last_res = e.res;
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit s,
                         input bit hold, output int acc);
        exp_t e;
        int   waitc;
        bit   sv;
        waitc = 0;
        sv    = s;
        acc   = -1;
`ifndef MAG_CMP_SIGNED_EN
        sv = 1'b0;
`endif
        while (!ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!ready) begin
            chk("ready_timeout", ready, 1'b1);
            return;
        end
        a     = x;
        b     = y;
        sm    = sv;
        start = 1'b1;
        e.res = ref_res(x, y, sv);
        e.lat = ref_lat(x, y);
        e.acc = cyc + 1;
        acc   = e.acc;
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("cleared_on_accept", {less, equal, greater, ready}, 4'b0000);
    endtask

    initial begin
        int acc;
        int t;
        bit prev_hold;
        bit hold;
        logic [W-1:0] x, y;

        #3;
        chk("reset_outputs", {ready, done, less, equal, greater}, 5'b10000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(16'h1234, 16'h1234, 1'b0, 1'b0, acc);
        issue(16'h8000, 16'h7FFF, 1'b0, 1'b0, acc);
`ifdef MAG_CMP_SIGNED_EN
        issue(16'h8000, 16'h7FFF, 1'b1, 1'b0, acc);
`endif
        issue(16'h12F0, 16'h12E0, 1'b0, 1'b0, acc);
        issue(16'h0001, 16'h0002, 1'b0, 1'b0, acc);

        // New operands offered mid-compare must be ignored
        issue(16'h12F0, 16'h12E0, 1'b0, 1'b0, acc);
        start = 1'b1;
        a     = 16'h0000;
        b     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;

        // Start held high: next compare accepted in the DONE cycle
        issue(16'h1234, 16'h1234, 1'b0, 1'b1, acc);
        issue(16'h0001, 16'h0002, 1'b0, 1'b1, acc);
        chk("b2b_no_gap", acc - last_done_cyc, 1);
        issue(16'hFFFF, 16'h0000, 1'b0, 1'b0, acc);
        chk("b2b_no_gap2", acc - last_done_cyc, 1);

        // Reset during the second COMPARE cycle
        issue(16'h1234, 16'h1234, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {done, less, equal, greater}, 4'b0000);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h00FF, 16'h00FE, 1'b0, 1'b0, acc);

        prev_hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0: y = W'($urandom);
                1: y = x;
                2: y = x ^ (W'($urandom_range(1, 15)) << (S * $urandom_range(0, N - 1)));
                default: y = x + W'(1);
            endcase
            hold = (i < 59) && ($urandom_range(0, 3) == 0);
            issue(x, y, bit'($urandom_range(0, 1)), hold, acc);
            prev_hold = hold;
        end

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("result_held", {less, equal, greater}, last_res);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mag_compare_seq.md
MAG_COMPARE_SEQ -- requirements
Module: mag_compare_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter STEP, default 4: bits compared per cycle; WIDTH SHALL be a multiple of STEP, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a compare; sampled only when ready=1.
REQ-006 SHALL have port a  input  WIDTH  operand A, captured on an accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B, captured on an accepted start.
REQ-008 SHALL have port signed_mode  input  1  two's-complement compare; present only with MAG_CMP_SIGNED_EN.
REQ-009 SHALL have port ready  output  1  high in IDLE and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result is valid.
REQ-011 SHALL have ports less, equal, greater  output  1 each  registered result, one-hot once valid.

Function
REQ-012 SHALL implement the FSM states IDLE, COMPARE and DONE.
REQ-013 SHALL accept a start, i.e. start=1 and ready=1, by capturing a, b (and signed_mode), setting chunk index to N-1 (N=WIDTH/STEP) and entering COMPARE.
REQ-014 SHALL, in each COMPARE cycle, compare the STEP-bit chunk at the index, scanning MSB-first.
REQ-015 SHALL, when a chunk differs, register less/greater from that chunk and enter DONE (early exit).
REQ-016 SHALL, when a chunk is equal and the index is nonzero, decrement the index; when it is equal and the index is 0, register equal=1 and enter DONE.
REQ-017 SHALL assert done for exactly the one DONE cycle; DONE SHALL go to IDLE unless a new start is accepted, in which case it goes to COMPARE.
REQ-018 SHALL have a latency from the acceptance edge to done=1 of k cycles, where k = position of the first differing chunk counted from the MSB (1..N); k = N when the operands are equal.
REQ-019 SHALL hold less/equal/greater stable from DONE until the next accepted start; on acceptance all three SHALL clear to 0.
REQ-020 SHALL ignore start while in COMPARE (ready=0), leaving the captured operands unchanged.
REQ-021 SHALL never assert more than one of less/equal/greater at once.

Reset
REQ-022 SHALL, on rst_n=0, immediately force state=IDLE, chunk index=0, captured operands=0, done=0, less=0, equal=0, greater=0, ready=1 (after release).
REQ-023 SHALL, when reset occurs mid-COMPARE, discard the in-flight compare with no done pulse.
REQ-024 SHALL accept a start on the first rising edge after reset release.

Configuration
REQ-025 SHALL, with MAG_CMP_SIGNED_EN defined, provide the signed_mode port; when the captured signed_mode=1, the MSB chunk compare SHALL treat bit WIDTH-1 of each operand as a sign bit (inverted before unsigned compare), and lower chunks SHALL be compared unsigned.
REQ-026 SHALL, without MAG_CMP_SIGNED_EN, omit the port and perform an unsigned-only compare with identical timing.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/COMPARE/DONE) and the result encoding constants in shared package mag_cmp_pkg.
REQ-028 SHALL implement the per-chunk compare as combinational sub-module chunk_cmp, with parameter STEP, inputs x, y and msb_signed, and outputs lt, eq, gt.

Verification (WIDTH=16, STEP=4)
REQ-029 SHALL verify: a=0x1234, b=0x1234 -> done 4 cycles after acceptance, equal=1.
REQ-030 SHALL verify: a=0x8000, b=0x7FFF, unsigned -> done after 1 cycle, greater=1; with signed_mode=1 (MAG_CMP_SIGNED_EN) -> less=1.
REQ-031 SHALL verify: a=0x12F0, b=0x12E0 -> done after 3 cycles, greater=1; then a=0x0001, b=0x0002 -> done after 4 cycles, less=1.
REQ-032 SHALL verify: start pulsed with new operands while in COMPARE -> ignored; the original result is produced with unchanged latency.
REQ-033 SHALL verify: rst_n low during the 2nd COMPARE cycle -> all outputs 0 immediately and no done pulse; a start after release completes normally.
REQ-034 SHALL verify: start held high through the DONE cycle -> back-to-back compares with no idle gap, and the results clear on acceptance.
